hazard_ctrl: RTL and testbench

- Stall/flush controller for the 5-stage pipeline; handles the hazards that fwd_unit cannot resolve by forwarding.
- Consumes decode-stage source register fields and EX-stage destination/load information.
- Produces PC/IF-ID write enables, an ID/EX bubble and an IF/ID flush.
- Also sequences the multi-cycle multiply/divide unit (MDU) with a busy counter, and keeps a saturating stall-cycle counter.

---
 rtl/hazard_ctrl_pkg.sv | 24 ++
 rtl/hazard_ctrl_if.sv | 42 ++++
 rtl/hazard_ctrl_cmp.sv | 17 +
 rtl/hazard_ctrl.sv | 114 +++++++++++
 tb/tb_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: register width, MDU sequencer states and the
// bubble/flush control bundle consumed by the pipeline registers.
package hazard_ctrl_pkg;

    localparam int REG_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_bubble;
        logic ifid_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1, ifid_flush: 1'b1};
    localparam pipe_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b1, ifid_flush: 1'b1};
    localparam pipe_ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1, ifid_flush: 1'b0};
    localparam pipe_ctrl_t CTRL_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0, ifid_flush: 1'b0};

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: decode/execute hazard fields in,
// stall/flush controls and MDU sequencing status out.
interface hazard_if #(
    parameter int REG_W = hazard_ctrl_pkg::REG_W,
    parameter int CNT_W = 16
);

    logic [REG_W-1:0] ifid_op1;
    logic [REG_W-1:0] ifid_op2;
    logic             ifid_uses_op2;
    logic             ifid_mdu;
    logic [REG_W-1:0] ifid_dest;
    logic [REG_W-1:0] idex_op1;
    logic             idex_memread;
    logic             branch_taken;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_bubble;
    logic             ifid_flush;
    logic             mdu_start;
    logic             mdu_busy;
    logic             mdu_done;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: supplies hazard fields, consumes controls.
    modport master (
        output ifid_op1, ifid_op2, ifid_uses_op2, ifid_mdu, ifid_dest,
        output idex_op1, idex_memread, branch_taken,
        input  pc_write, ifid_write, idex_bubble, ifid_flush,
        input  mdu_start, mdu_busy, mdu_done, stall_cnt
    );

    // Controller side.
    modport slave (
        input  ifid_op1, ifid_op2, ifid_uses_op2, ifid_mdu, ifid_dest,
        input  idex_op1, idex_memread, branch_taken,
        output pc_write, ifid_write, idex_bubble, ifid_flush,
        output mdu_start, mdu_busy, mdu_done, stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_cmp.sv
// Register-match comparator: flags when an enabled producer destination
// matches either source operand of the decode-stage instruction.
module hazard_cmp #(
    parameter int REG_W = 4
) (
    input  logic             en,
    input  logic [REG_W-1:0] dst,
    input  logic [REG_W-1:0] op1,
    input  logic [REG_W-1:0] op2,
    input  logic             uses_op2,
    output logic             hit
);

    // op2 is ignored unless the instruction actually reads it.
    assign hit = en & ((dst == op1) | (uses_op2 & (dst == op2)));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for hazards forwarding cannot resolve, plus the
// multi-cycle MDU busy sequencer and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W       = hazard_ctrl_pkg::REG_W,
    parameter int MDU_LATENCY = 8,
    parameter int CNT_W       = 16
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hif
);

    localparam logic [7:0]       CNT_LOAD = 8'(MDU_LATENCY - 1);
    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mdu_state_e       state_r;
    logic [7:0]       cnt_r;
    logic [REG_W-1:0] mdu_dst_r;
    logic [CNT_W-1:0] stall_cnt_r;

    logic       busy_s;
    logic       done_s;
    logic       load_use_s;
    logic       dst_hit_s;
    logic       mdu_dep_s;
    logic       start_s;
    pipe_ctrl_t ctrl_s;

    assign busy_s    = (state_r == ST_BUSY);
    assign done_s    = busy_s & (cnt_r == 8'd0);
    // Any MDU op in ID while busy must wait, even without a register match.
    assign mdu_dep_s = dst_hit_s | (busy_s & hif.ifid_mdu);

    hazard_cmp #(.REG_W(REG_W)) u_load_cmp (
        .en       (hif.idex_memread),
        .dst      (hif.idex_op1),
        .op1      (hif.ifid_op1),
        .op2      (hif.ifid_op2),
        .uses_op2 (hif.ifid_uses_op2),
        .hit      (load_use_s)
    );

    hazard_cmp #(.REG_W(REG_W)) u_mdu_cmp (
        .en       (busy_s),
        .dst      (mdu_dst_r),
        .op1      (hif.ifid_op1),
        .op2      (hif.ifid_op2),
        .uses_op2 (hif.ifid_uses_op2),
        .hit      (dst_hit_s)
    );

    // Prioritised stall/flush decision and MDU launch qualification.
    always_comb begin
        ctrl_s  = CTRL_RUN;
        start_s = 1'b0;
        if (rst) begin
            ctrl_s = CTRL_RESET;
        end else if (hif.branch_taken) begin
            ctrl_s = CTRL_FLUSH;
        end else if (load_use_s | mdu_dep_s) begin
            ctrl_s = CTRL_STALL;
        end else begin
            ctrl_s  = CTRL_RUN;
            start_s = hif.ifid_mdu & ~busy_s;
        end
    end

    assign hif.pc_write    = ctrl_s.pc_write;
    assign hif.ifid_write  = ctrl_s.ifid_write;
    assign hif.idex_bubble = ctrl_s.idex_bubble;
    assign hif.ifid_flush  = ctrl_s.ifid_flush;
    assign hif.mdu_start   = start_s;
    assign hif.mdu_busy    = busy_s & ~rst;
    assign hif.mdu_done    = done_s & ~rst;
    assign hif.stall_cnt   = stall_cnt_r;

    // MDU sequencer state, busy down-counter and stall performance counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            mdu_dst_r   <= {REG_W{1'b0}};
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r   <= ST_BUSY;
                        cnt_r     <= CNT_LOAD;
                        mdu_dst_r <= hif.ifid_dest;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == 8'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 8'd0;
                end
            endcase
            if (!ctrl_s.pc_write && (stall_cnt_r != STALL_MAX)) begin
                stall_cnt_r <= stall_cnt_r + STALL_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int REG_W       = 4;
    localparam int MDU_LATENCY = 8;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    // Model state: remaining busy cycles (0 = idle), destination, stall count.
    int m_left  = 0;
    int m_dst   = 0;
    int m_stall = 0;

    logic e_pc, e_ifw, e_bub, e_fl, e_st, e_busy, e_done;

    hazard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hif ();

    hazard_ctrl #(.REG_W(REG_W), .MDU_LATENCY(MDU_LATENCY), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_eval();
        bit busy, lu, md;
        busy = (m_left > 0);
        lu = hif.idex_memread && ((hif.idex_op1 == hif.ifid_op1) ||
                                  (hif.ifid_uses_op2 && (hif.idex_op1 == hif.ifid_op2)));
        md = busy && (hif.ifid_mdu || (int'(hif.ifid_op1) == m_dst) ||
                      (hif.ifid_uses_op2 && (int'(hif.ifid_op2) == m_dst)));
        e_busy = busy && !rst;
        e_done = (m_left == 1) && !rst;
        e_st   = 1'b0;
        if (rst) begin
            {e_pc, e_ifw, e_bub, e_fl} = 4'b0011;
        end else if (hif.branch_taken) begin
            {e_pc, e_ifw, e_bub, e_fl} = 4'b1111;
        end else if (lu || md) begin
            {e_pc, e_ifw, e_bub, e_fl} = 4'b0010;
        end else begin
            {e_pc, e_ifw, e_bub, e_fl} = 4'b1100;
            e_st = hif.ifid_mdu && !busy;
        end
    endtask

    task automatic check_cycle(input string tag);
        @(negedge clk);
        model_eval();
        chk({tag, ".pc_write"},    32'(hif.pc_write),    32'(e_pc));
        chk({tag, ".ifid_write"},  32'(hif.ifid_write),  32'(e_ifw));
        chk({tag, ".idex_bubble"}, 32'(hif.idex_bubble), 32'(e_bub));
        chk({tag, ".ifid_flush"},  32'(hif.ifid_flush),  32'(e_fl));
        chk({tag, ".mdu_start"},   32'(hif.mdu_start),   32'(e_st));
        chk({tag, ".mdu_busy"},    32'(hif.mdu_busy),    32'(e_busy));
        chk({tag, ".mdu_done"},    32'(hif.mdu_done),    32'(e_done));
        chk({tag, ".stall_cnt"},   32'(hif.stall_cnt),   32'(m_stall));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_left  = 0;
            m_stall = 0;
        end else begin
            if (!e_pc && (m_stall < CNT_MAX)) m_stall++;
            if (e_st) begin
                m_left = MDU_LATENCY;
                m_dst  = int'(hif.ifid_dest);
            end else if (m_left > 0) begin
                m_left--;
            end
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        check_cycle(tag);
        advance();
    endtask

    task automatic set_idle();
        hif.ifid_op1      = '0;
        hif.ifid_op2      = '0;
        hif.ifid_uses_op2 = 1'b0;
        hif.ifid_mdu      = 1'b0;
        hif.ifid_dest     = '0;
        hif.idex_op1      = '0;
        hif.idex_memread  = 1'b0;
        hif.branch_taken  = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        cycle("reset");
        rst = 1'b0;
    endtask

    task automatic launch(input logic [REG_W-1:0] dest);
        set_idle();
        hif.ifid_mdu  = 1'b1;
        hif.ifid_dest = dest;
        hif.ifid_op1  = 4'd7;
        cycle("launch");
    endtask

    initial begin
        int busy_n, done_at;
        set_idle();
        rst = 1'b1;
        advance();
        check_cycle("rst_hold");
        chk("rst_bubble", 32'(hif.idex_bubble), 32'd1);
        chk("rst_flush", 32'(hif.ifid_flush), 32'd1);
        chk("rst_cnt", 32'(hif.stall_cnt), 32'd0);
        advance();
        rst = 1'b0;

        // Load-use: exactly one stall cycle, then flow.
        hif.idex_memread = 1'b1; hif.idex_op1 = 4'd2; hif.ifid_op1 = 4'd2;
        check_cycle("lu_stall");
        chk("lu_pc", 32'(hif.pc_write), 32'd0);
        advance();
        hif.idex_memread = 1'b0;
        check_cycle("lu_go");
        chk("lu_cnt", 32'(hif.stall_cnt), 32'd1);
        chk("lu_pc_go", 32'(hif.pc_write), 32'd1);
        advance();
        hif.idex_memread = 1'b1; hif.ifid_op1 = 4'd3; hif.ifid_op2 = 4'd2; hif.ifid_uses_op2 = 1'b0;
        check_cycle("lu_op2_unused");
        chk("lu_op2_unused_pc", 32'(hif.pc_write), 32'd1);
        advance();
        hif.ifid_uses_op2 = 1'b1;
        check_cycle("lu_op2_used");
        chk("lu_op2_used_pc", 32'(hif.pc_write), 32'd0);
        advance();

        // MDU launch with independent traffic.
        do_reset();
        hif.ifid_mdu = 1'b1; hif.ifid_dest = 4'd5; hif.ifid_op1 = 4'd7;
        check_cycle("mdu_launch");
        chk("mdu_launch_start", 32'(hif.mdu_start), 32'd1);
        advance();
        set_idle();
        hif.ifid_op1 = 4'd3;
        busy_n = 0; done_at = 0;
        for (int i = 1; i <= 8; i++) begin
            check_cycle("mdu_indep");
            if (hif.mdu_busy === 1'b1) busy_n++;
            if (hif.mdu_done === 1'b1) done_at = i;
            advance();
        end
        chk("mdu_busy_cycles", 32'(busy_n), 32'd8);
        chk("mdu_done_cycle", 32'(done_at), 32'd8);
        check_cycle("mdu_after");
        chk("mdu_after_busy", 32'(hif.mdu_busy), 32'd0);
        advance();

        // MDU dependency stalls through done.
        do_reset();
        launch(4'd5);
        set_idle();
        hif.ifid_op1 = 4'd5;
        for (int i = 1; i <= 9; i++) begin
            check_cycle("mdu_dep");
            if (i == 8) begin
                chk("dep_done", 32'(hif.mdu_done), 32'd1);
                chk("dep_cnt", 32'(hif.stall_cnt), 32'd7);
                chk("dep_pc_done", 32'(hif.pc_write), 32'd0);
            end
            if (i == 9) chk("dep_proceed", 32'(hif.pc_write), 32'd1);
            advance();
        end

        // Branch has top priority over load-use and MDU launch.
        do_reset();
        hif.idex_memread = 1'b1; hif.idex_op1 = 4'd2; hif.ifid_op1 = 4'd2;
        hif.ifid_mdu = 1'b1; hif.ifid_dest = 4'd9; hif.branch_taken = 1'b1;
        check_cycle("branch");
        chk("br_flush", 32'(hif.ifid_flush), 32'd1);
        chk("br_bubble", 32'(hif.idex_bubble), 32'd1);
        chk("br_pc", 32'(hif.pc_write), 32'd1);
        chk("br_start", 32'(hif.mdu_start), 32'd0);
        advance();
        set_idle();
        check_cycle("br_nolaunch");
        chk("br_nolaunch_busy", 32'(hif.mdu_busy), 32'd0);
        advance();

        // Reset in the middle of an MDU operation.
        do_reset();
        launch(4'd5);
        set_idle();
        cycle("mid_b1");
        cycle("mid_b2");
        rst = 1'b1;
        check_cycle("mid_rst");
        chk("mid_rst_busy", 32'(hif.mdu_busy), 32'd0);
        chk("mid_rst_pc", 32'(hif.pc_write), 32'd0);
        chk("mid_rst_done", 32'(hif.mdu_done), 32'd0);
        advance();
        rst = 1'b0;
        check_cycle("mid_after");
        chk("mid_after_busy", 32'(hif.mdu_busy), 32'd0);
        chk("mid_after_cnt", 32'(hif.stall_cnt), 32'd0);
        advance();
        for (int i = 0; i < 10; i++) begin
            check_cycle("mid_quiet");
            chk("mid_no_done", 32'(hif.mdu_done), 32'd0);
            advance();
        end

        // Back-to-back MDU ops: second launches one cycle after done.
        do_reset();
        launch(4'd5);
        set_idle();
        hif.ifid_mdu = 1'b1; hif.ifid_dest = 4'd6;
        for (int i = 1; i <= 9; i++) begin
            check_cycle("b2b");
            if (i <= 8) chk("b2b_stall", 32'(hif.pc_write), 32'd0);
            if (i == 9) chk("b2b_restart", 32'(hif.mdu_start), 32'd1);
            advance();
        end
        set_idle();
        for (int i = 0; i < 9; i++) cycle("b2b_drain");

        // Stall counter saturates.
        do_reset();
        hif.idex_memread = 1'b1; hif.idex_op1 = 4'd2; hif.ifid_op1 = 4'd2;
        for (int i = 0; i < 20; i++) cycle("sat");
        check_cycle("sat_end");
        chk("sat_value", 32'(hif.stall_cnt), 32'(CNT_MAX));
        advance();

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst               = ($urandom_range(0, 59) == 0);
            hif.ifid_op1      = REG_W'($urandom_range(0, 3));
            hif.ifid_op2      = REG_W'($urandom_range(0, 3));
            hif.ifid_uses_op2 = 1'($urandom_range(0, 1));
            hif.ifid_mdu      = ($urandom_range(0, 3) == 0);
            hif.ifid_dest     = REG_W'($urandom_range(0, 3));
            hif.idex_op1      = REG_W'($urandom_range(0, 3));
            hif.idex_memread  = ($urandom_range(0, 3) == 0);
            hif.branch_taken  = ($urandom_range(0, 7) == 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
